// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display prefetch has fixed slots every 4th pixel,
// CPU accesses slip into the free cycles and complete with a fixed 2-cycle latency.
module vga_fb_arbiter #(
  parameter int H_VIS    = 640,
  parameter int V_VIS    = 480,
  parameter int FB_WORDS = 76800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [16:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  pixel
);

  localparam logic [9:0]  H_VIS_W   = 10'(H_VIS);
  localparam logic [9:0]  H_FETCH_W = 10'(H_VIS - 4);
  localparam logic [9:0]  V_VIS_W   = 10'(V_VIS);
  localparam logic [16:0] FB_LIM    = 17'(FB_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state;
  logic        rd_op;
  logic        oor;
  logic [16:0] disp_addr;
  logic        disp_pend;
  logic [15:0] pf;
  logic [15:0] cur;

  logic vis_line;
  logic vis_pix;
  logic disp_slot;
  logic cpu_issue;
  logic addr_ok;

  function automatic logic [3:0] nib_sel(input logic [15:0] w, input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0:    n = w[3:0];
      2'd1:    n = w[7:4];
      2'd2:    n = w[11:8];
      default: n = w[15:12];
    endcase
    return n;
  endfunction

  // The x == 1020 slot fetches the first word of the line during back porch,
  // so the last in-line slot is H_VIS-8 and slots are never adjacent.
  assign vis_line  = (y < V_VIS_W);
  assign vis_pix   = vis_line && (x < H_VIS_W);
  assign disp_slot = vis_line && ((x == 10'd1020) || ((x < H_FETCH_W) && (x[1:0] == 2'b00)));
  assign cpu_issue = (state == S_IDLE) && cpu_req && !disp_slot;
  assign addr_ok   = (cpu_addr < FB_LIM);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = disp_addr;
    mem_wdata = cpu_wdata;
    if (!rst) begin
      if (disp_slot) begin
        mem_en = 1'b1;
      end else if (cpu_issue && addr_ok) begin
        mem_en   = 1'b1;
        mem_we   = cpu_we;
        mem_addr = cpu_addr;
      end
    end
  end

  // Display path: fetch -> pf capture (disp_pend) -> cur / pixel register
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_addr <= '0;
      disp_pend <= 1'b0;
      pf        <= '0;
      cur       <= '0;
      pixel     <= '0;
    end else begin
      disp_pend <= disp_slot;
      if (!vis_line)
        disp_addr <= '0;
      else if (disp_slot)
        disp_addr <= disp_addr + 17'd1;
      if (disp_pend)
        pf <= mem_rdata;
      if (vis_pix && (x[1:0] == 2'b00))
        cur <= pf;
      if (vis_pix)
        pixel <= nib_sel((x[1:0] == 2'b00) ? pf : cur, x[1:0]);
      else
        pixel <= '0;
    end
  end

  // CPU path: issue (IDLE) -> data return (WAIT) -> ack pulse (ACK)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      rd_op     <= 1'b0;
      oor       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cpu_ack <= 1'b0;
          if (cpu_issue) begin
            rd_op <= !cpu_we;
            oor   <= !addr_ok;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rd_op)
            cpu_rdata <= oor ? 16'h0000 : mem_rdata;
          cpu_ack <= 1'b1;
          state   <= S_ACK;
        end
        S_ACK: begin
          cpu_ack <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          cpu_ack <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: frame sweep, pixel pipeline, CPU arbitration,
// out-of-range access and reset abort, against a word k = 16'h3210 + k memory.
module tb_vga_fb_arbiter;
  localparam int HV  = 640;
  localparam int VV  = 16;
  localparam int FBW = VV * 160;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x, y;
  logic        cpu_req, cpu_we;
  logic [16:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [3:0]  pixel;

  int total = 0;
  int bad   = 0;

  logic        n_rst = 1'b1;
  logic        n_req = 1'b0;
  logic        n_we  = 1'b0;
  logic [16:0] n_addr = '0;
  logic [15:0] n_wd  = '0;

  // single-entry write log on top of the k -> 16'h3210 + k pattern
  logic        have_w = 1'b0;
  logic [16:0] w_addr = '0;
  logic [15:0] w_data = '0;

  vga_fb_arbiter #(.H_VIS(HV), .V_VIS(VV), .FB_WORDS(FBW)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pixel(pixel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && (mem_addr < 17'(FBW))) begin
      if (mem_we) begin
        have_w    <= 1'b1;
        w_addr    <= mem_addr;
        w_data    <= mem_wdata;
        mem_rdata <= 16'hDEAD;
      end else begin
        mem_rdata <= (have_w && (w_addr == mem_addr)) ? w_data : 16'h3210 + mem_addr[15:0];
      end
    end else begin
      mem_rdata <= 16'hDEAD;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Applies staged inputs just after a rising edge and returns mid-cycle.
  task automatic tick(input int xv, input int yv);
    @(posedge clk);
    #1;
    x         = 10'(xv);
    y         = 10'(yv);
    rst       = n_rst;
    cpu_req   = n_req;
    cpu_we    = n_we;
    cpu_addr  = n_addr;
    cpu_wdata = n_wd;
    #3;
  endtask

  task automatic do_reset();
    n_rst = 1'b1; n_req = 1'b0;
    tick(700, VV + 5);
    tick(700, VV + 5);
    n_rst = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1; n_req = 1'b0;
    tick(700, VV + 5);
    tick(0, 0);
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%b want=0", mem_en); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", cpu_ack); end
    total++; if (cpu_rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0000", cpu_rdata); end
    total++; if (pixel !== 4'h0) begin bad++; $display("FAIL rst_pixel got=%h want=0", pixel); end
    n_rst = 1'b0;
  endtask

  task automatic test_frame_sweep();
    int exp_addr;
    int line_cnt;
    int px, py, xx;
    logic [15:0] w;
    logic [3:0]  ep;
    do_reset();
    exp_addr = 0; px = 700; py = VV + 5;
    for (int yy = 0; yy < VV + 2; yy++) begin
      line_cnt = 0;
      for (int i = 0; i < 800; i++) begin
        xx = (i < 144) ? 880 + i : i - 144;
        tick(xx, yy);
        if (mem_en === 1'b1) begin
          total++;
          if (mem_addr !== 17'(exp_addr) || mem_we !== 1'b0) begin
            bad++; $display("FAIL sweep_addr y=%0d x=%0d got=%0d we=%b want=%0d", yy, xx, mem_addr, mem_we, exp_addr);
          end
          exp_addr++; line_cnt++;
        end
        if (py < VV && px < HV) begin
          w  = 16'h3210 + 16'(py * 160 + px / 4);
          ep = 4'(w >> (4 * (px % 4)));
        end else begin
          ep = 4'h0;
        end
        total++;
        if (pixel !== ep) begin
          bad++; $display("FAIL sweep_pixel y=%0d x=%0d got=%h want=%h", py, px, pixel, ep);
        end
        px = xx; py = yy;
      end
      total++;
      if (line_cnt !== ((yy < VV) ? 160 : 0)) begin
        bad++; $display("FAIL sweep_line_fetches y=%0d got=%0d want=%0d", yy, line_cnt, (yy < VV) ? 160 : 0);
      end
    end
    total++; if (exp_addr !== FBW) begin bad++; $display("FAIL sweep_frame_fetches got=%0d want=%0d", exp_addr, FBW); end
    tick(1020, 0);
    total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL sweep_next_frame_en got=%b want=1", mem_en); end
    total++; if (mem_addr !== 17'd0) begin bad++; $display("FAIL sweep_vblank_clear got=%0d want=0", mem_addr); end
  endtask

  task automatic test_pixel_seq();
    logic [3:0] exp_px [8];
    exp_px = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd1, 4'd1, 4'd2, 4'd3};
    do_reset();
    tick(1020, 0);
    for (int xx = 1021; xx <= 1024; xx++) begin
      tick(xx % 1024, 0);
      total++; if (pixel !== 4'h0) begin bad++; $display("FAIL pix_porch x=%0d got=%h want=0", xx, pixel); end
    end
    for (int k = 0; k < 8; k++) begin
      tick(k + 1, 0);
      total++;
      if (pixel !== exp_px[k]) begin bad++; $display("FAIL pix_seq x=%0d got=%h want=%h", k + 1, pixel, exp_px[k]); end
    end
    tick(640, 0);
    tick(641, 0);
    total++; if (pixel !== 4'h0) begin bad++; $display("FAIL pix_x640 got=%h want=0", pixel); end
    tick(4, VV);
    tick(5, VV);
    total++; if (pixel !== 4'h0) begin bad++; $display("FAIL pix_vblank got=%h want=0", pixel); end
  endtask

  task automatic test_cpu_read_slot();
    do_reset();
    tick(0, 10);
    tick(1, 10);
    n_req = 1'b1; n_we = 1'b0; n_addr = 17'd5;
    tick(2, 10);
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL rd_issue_en got=%b/%b want=1/0", mem_en, mem_we); end
    total++; if (mem_addr !== 17'd5) begin bad++; $display("FAIL rd_issue_addr got=%0d want=5", mem_addr); end
    tick(3, 10);
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rd_wait_en got=%b want=0", mem_en); end
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rd_wait_ack got=%b want=0", cpu_ack); end
    tick(4, 10);
    total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL rd_ack got=%b want=1", cpu_ack); end
    total++; if (cpu_rdata !== 16'h3215) begin bad++; $display("FAIL rd_data got=%h want=3215", cpu_rdata); end
    total++; if (mem_en !== 1'b1 || mem_addr !== 17'd1) begin bad++; $display("FAIL rd_disp_fetch got=%b/%0d want=1/1", mem_en, mem_addr); end
    n_req = 1'b0;
    tick(5, 10);
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rd_ack_pulse got=%b want=0", cpu_ack); end
    total++; if (pixel !== 4'h0) begin bad++; $display("FAIL rd_pf_intact0 got=%h want=0", pixel); end
    tick(6, 10);
    total++; if (pixel !== 4'h1) begin bad++; $display("FAIL rd_pf_intact1 got=%h want=1", pixel); end
  endtask

  task automatic test_cpu_write_deferred();
    do_reset();
    n_req = 1'b1; n_we = 1'b1; n_addr = 17'd100; n_wd = 16'hBEEF;
    tick(0, 0);
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'd0) begin
      bad++; $display("FAIL wr_disp_priority got=%b/%b/%0d want=1/0/0", mem_en, mem_we, mem_addr); end
    tick(1, 0);
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL wr_issue_en got=%b/%b want=1/1", mem_en, mem_we); end
    total++; if (mem_addr !== 17'd100 || mem_wdata !== 16'hBEEF) begin
      bad++; $display("FAIL wr_issue_bus got=%0d/%h want=100/beef", mem_addr, mem_wdata); end
    tick(2, 0);
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL wr_early_ack got=%b want=0", cpu_ack); end
    tick(3, 0);
    total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b want=1", cpu_ack); end
    n_req = 1'b0; n_we = 1'b0;
    tick(4, 0);
    total++; if (have_w !== 1'b1 || w_addr !== 17'd100 || w_data !== 16'hBEEF) begin
      bad++; $display("FAIL wr_mem got=%b/%0d/%h want=1/100/beef", have_w, w_addr, w_data); end
    n_req = 1'b1; n_addr = 17'd100;
    tick(10, 20);
    tick(11, 20);
    tick(12, 20);
    total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'hBEEF) begin
      bad++; $display("FAIL wr_readback got=%b/%h want=1/beef", cpu_ack, cpu_rdata); end
    n_req = 1'b0;
    tick(13, 20);
  endtask

  task automatic test_out_of_range();
    n_req = 1'b1; n_we = 1'b0; n_addr = 17'(FBW);
    tick(100, 20);
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL oor_en got=%b/%b want=0/0", mem_en, mem_we); end
    tick(101, 20);
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL oor_early_ack got=%b want=0", cpu_ack); end
    tick(102, 20);
    total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL oor_ack got=%b want=1", cpu_ack); end
    total++; if (cpu_rdata !== 16'h0000) begin bad++; $display("FAIL oor_rdata got=%h want=0000", cpu_rdata); end
    n_req = 1'b0;
    tick(103, 20);
    n_req = 1'b1; n_addr = 17'(FBW - 1);
    tick(110, 20);
    total++; if (mem_en !== 1'b1 || mem_addr !== 17'(FBW - 1)) begin
      bad++; $display("FAIL last_word_issue got=%b/%0d want=1/%0d", mem_en, mem_addr, FBW - 1); end
    tick(111, 20);
    tick(112, 20);
    total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h3C0F) begin
      bad++; $display("FAIL last_word_read got=%b/%h want=1/3c0f", cpu_ack, cpu_rdata); end
    n_req = 1'b0;
    tick(113, 20);
  endtask

  task automatic test_reset_in_wait();
    n_req = 1'b1; n_we = 1'b0; n_addr = 17'd7;
    tick(200, 20);
    n_rst = 1'b1;
    tick(201, 20);
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL rw_mem_in_rst got=%b/%b want=0/0", mem_en, mem_we); end
    n_rst = 1'b0; n_req = 1'b0;
    tick(202, 20);
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rw_no_ack got=%b want=0", cpu_ack); end
    total++; if (cpu_rdata !== 16'h0000 || pixel !== 4'h0) begin
      bad++; $display("FAIL rw_outputs_clear got=%h/%h want=0000/0", cpu_rdata, pixel); end
    tick(203, 20);
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rw_no_late_ack got=%b want=0", cpu_ack); end
    n_req = 1'b1;
    tick(204, 20);
    total++; if (mem_en !== 1'b1 || mem_addr !== 17'd7) begin bad++; $display("FAIL rw_reissue got=%b/%0d want=1/7", mem_en, mem_addr); end
    tick(205, 20);
    tick(206, 20);
    total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h3217) begin
      bad++; $display("FAIL rw_reissue_ack got=%b/%h want=1/3217", cpu_ack, cpu_rdata); end
    n_req = 1'b0;
    tick(207, 20);
  endtask

  initial begin
    rst = 1'b1; x = 10'd700; y = 10'(VV + 5);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    test_reset();
    test_frame_sweep();
    test_pixel_seq();
    test_cpu_read_slot();
    test_cpu_write_deferred();
    test_out_of_range();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
